l15_vc_assoc: RTL and testbench
===============================

L15_VC_ASSOC -- requirements
Module: l15_vc_assoc

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 36, meaning line address width (tag+index).
REQ-002 SHALL have parameter DATA_WIDTH, default 128, meaning cache line width.
REQ-003 SHALL have parameter NUM_ENTRIES, default 16, meaning entry count; power of two, >=2; CW = log2(NUM_ENTRIES)+1.
REQ-004 SHALL have port clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports ins_val in 1, ins_addr in ADDR_WIDTH, ins_data in DATA_WIDTH, ins_dirty in 1 (1=M, 0=E), and ins_rdy out 1; together these are the evicted-line insert.
REQ-007 SHALL have ports lkp_val in 1 and lkp_addr in ADDR_WIDTH; together these are the lookup request.
REQ-008 SHALL have ports lkp_resp_val out 1, lkp_hit out 1, lkp_data out DATA_WIDTH and lkp_dirty out 1; together these are the registered lookup response.
REQ-009 SHALL have ports inv_val in 1, inv_addr in ADDR_WIDTH and inv_hit out 1 (combinational); together these are the coherence invalidate.
REQ-010 SHALL have ports wb_val out 1, wb_addr out ADDR_WIDTH, wb_data out DATA_WIDTH and wb_rdy in 1; together these are the dirty writeback.
REQ-011 SHALL have port count  out  CW  number of valid entries.

Function
REQ-012 SHALL hold per entry: addr, data, state in {I, E, M}; fully associative, at most one valid entry per address.
REQ-013 SHALL evaluate lookup, invalidate and insert against pre-edge state; all updates take effect at the same edge.
REQ-014 Insert SHALL fire when ins_val && ins_rdy; ins_rdy = !wb_val.
REQ-015 Insert target: the matching valid entry if present (overwritten, no writeback); else the lowest-index I entry; else the entry at round-robin pointer rr.
REQ-016 rr SHALL advance by one, modulo NUM_ENTRIES, only when rr's entry is replaced.
REQ-017 Replacing an M entry SHALL load its addr/data into the writeback register and set wb_val next cycle.
REQ-018 Inserted entry state SHALL be M if ins_dirty, else E.
REQ-019 Lookup hit SHALL remove the entry (state I); response appears exactly one cycle after lkp_val with lkp_resp_val=1; lkp_dirty=1 if state was M.
REQ-020 On lookup miss, lkp_hit=0 and lkp_data=0.
REQ-021 Invalidate SHALL set the matching entry to I; inv_hit same cycle.
REQ-022 If the invalidated entry was M, its line SHALL go to the writeback register.
REQ-023 inv_val SHALL be accepted only when !wb_val (caller guarantees).
REQ-024 Invalidate SHALL take priority over lookup on the same entry: lookup reports miss.
REQ-025 If the same address is inserted, the inserted line SHALL remain valid.
REQ-026 Lookup on an address inserted in the same cycle SHALL miss.
REQ-027 wb_val SHALL hold with stable wb_addr/wb_data until wb_rdy; it clears the cycle after wb_rdy is sampled high.
REQ-028 count SHALL equal the valid-entry count after each edge; range 0..NUM_ENTRIES.

Reset
REQ-029 While rst_n=0, SHALL set all entries to I with addr/data 0, and set rr=0, count=0, wb_val=0, lkp_resp_val=0, lkp_hit=0, lkp_data=0, lkp_dirty=0; ins_rdy=1 after reset.
REQ-030 Reset mid-operation SHALL discard any pending writeback and in-flight lookup response.

Verification
REQ-031 Insert A=0x10 (E), data 0xAA, then lookup 0x10 -> next cycle lkp_hit=1, lkp_data=0xAA, lkp_dirty=0, count 1->0.
REQ-032 Fill 16 entries E, insert 17th -> replaces entry 0, rr=1, no wb_val, count=16.
REQ-033 Fill 16 with entry 0 dirty, insert new -> wb_val=1 with entry 0 addr/data, ins_rdy=0 until wb_rdy handshake.
REQ-034 Invalidate dirty 0x20 -> inv_hit=1, wb_val next cycle, count decrements; inv 0x99 absent -> inv_hit=0.
REQ-035 Same cycle: insert 0x30 and lookup 0x30 (absent) -> miss, then later lookup hits; same cycle inv+lookup 0x40 -> lkp_hit=0, inv_hit=1.
REQ-036 Assert rst_n low while wb_val=1 -> wb_val=0, count=0 immediately.

Source files
------------

// File: rtl/l15_vc_assoc_if.sv
// rtl/l15_vc_assoc_if.sv - Insert, lookup, invalidate and writeback bundle for the L1.5 victim cache
interface l15_vc_assoc_if #(
    parameter int ADDR_WIDTH  = 36,
    parameter int DATA_WIDTH  = 128,
    parameter int NUM_ENTRIES = 16
);
    localparam int CW = $clog2(NUM_ENTRIES) + 1;

    logic                  ins_val;
    logic [ADDR_WIDTH-1:0] ins_addr;
    logic [DATA_WIDTH-1:0] ins_data;
    logic                  ins_dirty;
    logic                  ins_rdy;

    logic                  lkp_val;
    logic [ADDR_WIDTH-1:0] lkp_addr;
    logic                  lkp_resp_val;
    logic                  lkp_hit;
    logic [DATA_WIDTH-1:0] lkp_data;
    logic                  lkp_dirty;

    logic                  inv_val;
    logic [ADDR_WIDTH-1:0] inv_addr;
    logic                  inv_hit;

    logic                  wb_val;
    logic [ADDR_WIDTH-1:0] wb_addr;
    logic [DATA_WIDTH-1:0] wb_data;
    logic                  wb_rdy;

    logic [CW-1:0]         count;

    modport slave (
        input  ins_val, ins_addr, ins_data, ins_dirty,
        output ins_rdy,
        input  lkp_val, lkp_addr,
        output lkp_resp_val, lkp_hit, lkp_data, lkp_dirty,
        input  inv_val, inv_addr,
        output inv_hit,
        output wb_val, wb_addr, wb_data,
        input  wb_rdy,
        output count
    );

    modport master (
        output ins_val, ins_addr, ins_data, ins_dirty,
        input  ins_rdy,
        output lkp_val, lkp_addr,
        input  lkp_resp_val, lkp_hit, lkp_data, lkp_dirty,
        output inv_val, inv_addr,
        input  inv_hit,
        input  wb_val, wb_addr, wb_data,
        output wb_rdy,
        input  count
    );
endinterface

// File: rtl/l15_vc_assoc.sv
// rtl/l15_vc_assoc.sv - Fully associative L1.5 victim cache with round-robin replacement and dirty writeback
module l15_vc_assoc #(
    parameter int ADDR_WIDTH  = 36,
    parameter int DATA_WIDTH  = 128,
    parameter int NUM_ENTRIES = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    l15_vc_assoc_if.slave  bus
);
    localparam int IW = $clog2(NUM_ENTRIES);
    localparam int CW = IW + 1;

    // Entry state: valid=0 is I, valid=1 with dirty=0/1 is E/M
    logic [NUM_ENTRIES-1:0] r_valid;
    logic [NUM_ENTRIES-1:0] r_dirty;
    logic [ADDR_WIDTH-1:0]  r_addr [NUM_ENTRIES];
    logic [DATA_WIDTH-1:0]  r_data [NUM_ENTRIES];
    logic [IW-1:0]          r_rr;

    logic                   r_wb_val;
    logic [ADDR_WIDTH-1:0]  r_wb_addr;
    logic [DATA_WIDTH-1:0]  r_wb_data;

    logic                   r_lkp_resp_val;
    logic                   r_lkp_hit;
    logic                   r_lkp_dirty;
    logic [DATA_WIDTH-1:0]  r_lkp_data;

    logic                   w_lkp_any, w_inv_any, w_ins_any, w_free_any;
    logic [IW-1:0]          w_lkp_idx, w_inv_idx, w_ins_idx, w_free_idx, w_tgt_idx;
    logic                   w_ins_fire, w_inv_hit, w_lkp_hit, w_rr_adv, w_evict_wb;
    logic [CW-1:0]          w_count;

    // Address match against pre-edge state; free slot search favours the lowest index
    always_comb begin
        w_lkp_any  = 1'b0;
        w_inv_any  = 1'b0;
        w_ins_any  = 1'b0;
        w_free_any = 1'b0;
        w_lkp_idx  = '0;
        w_inv_idx  = '0;
        w_ins_idx  = '0;
        w_free_idx = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (r_valid[i] && r_addr[i] == bus.lkp_addr) begin
                w_lkp_any = 1'b1;
                w_lkp_idx = IW'(i);
            end
            if (r_valid[i] && r_addr[i] == bus.inv_addr) begin
                w_inv_any = 1'b1;
                w_inv_idx = IW'(i);
            end
            if (r_valid[i] && r_addr[i] == bus.ins_addr) begin
                w_ins_any = 1'b1;
                w_ins_idx = IW'(i);
            end
        end
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (!r_valid[i]) begin
                w_free_any = 1'b1;
                w_free_idx = IW'(i);
            end
        end
    end

    // Resolve same-cycle interactions and pick the insert target
    always_comb begin
        w_ins_fire = bus.ins_val && !r_wb_val;
        w_inv_hit  = bus.inv_val && w_inv_any;
        // Invalidate beats lookup on the same entry; a line being (re)inserted this cycle is never returned
        w_lkp_hit  = bus.lkp_val && w_lkp_any
                     && !(w_inv_hit && w_inv_idx == w_lkp_idx)
                     && !(w_ins_fire && bus.ins_addr == bus.lkp_addr);
        w_tgt_idx  = r_rr;
        w_rr_adv   = 1'b0;
        w_evict_wb = 1'b0;
        if (w_ins_any) begin
            w_tgt_idx = w_ins_idx;
        end else if (w_free_any) begin
            w_tgt_idx = w_free_idx;
        end else if (w_inv_hit && r_dirty[w_inv_idx] && r_dirty[r_rr] && w_inv_idx != r_rr) begin
            // Both the invalidated line and the victim are dirty: only one writeback register,
            // so reuse the slot the invalidate is freeing and leave the rr victim alone
            w_tgt_idx = w_inv_idx;
        end else begin
            w_rr_adv   = 1'b1;
            // A victim already handed out by lookup or written back by invalidate needs no eviction writeback
            w_evict_wb = r_dirty[r_rr]
                         && !(w_lkp_hit && w_lkp_idx == r_rr)
                         && !(w_inv_hit && w_inv_idx == r_rr);
        end
    end

    // Valid-entry population count
    always_comb begin
        w_count = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            w_count = w_count + CW'(r_valid[i]);
        end
    end

    // Entry array and round-robin pointer update; insert wins over removal of the same slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_dirty <= '0;
            r_rr    <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                r_addr[i] <= '0;
                r_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (w_ins_fire && w_tgt_idx == IW'(i)) begin
                    r_valid[i] <= 1'b1;
                    r_dirty[i] <= bus.ins_dirty;
                    r_addr[i]  <= bus.ins_addr;
                    r_data[i]  <= bus.ins_data;
                end else if ((w_inv_hit && w_inv_idx == IW'(i)) || (w_lkp_hit && w_lkp_idx == IW'(i))) begin
                    r_valid[i] <= 1'b0;
                    r_dirty[i] <= 1'b0;
                end
            end
            if (w_ins_fire && w_rr_adv) begin
                r_rr <= r_rr + 1'b1;
            end
        end
    end

    // Writeback register: holds until handshake, loaded by dirty invalidate or dirty eviction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb_val  <= 1'b0;
            r_wb_addr <= '0;
            r_wb_data <= '0;
        end else if (r_wb_val) begin
            if (bus.wb_rdy) begin
                r_wb_val <= 1'b0;
            end
        end else if (w_inv_hit && r_dirty[w_inv_idx]) begin
            r_wb_val  <= 1'b1;
            r_wb_addr <= r_addr[w_inv_idx];
            r_wb_data <= r_data[w_inv_idx];
        end else if (w_ins_fire && w_evict_wb) begin
            r_wb_val  <= 1'b1;
            r_wb_addr <= r_addr[r_rr];
            r_wb_data <= r_data[r_rr];
        end
    end

    // Registered lookup response, one cycle after the request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lkp_resp_val <= 1'b0;
            r_lkp_hit      <= 1'b0;
            r_lkp_dirty    <= 1'b0;
            r_lkp_data     <= '0;
        end else begin
            r_lkp_resp_val <= bus.lkp_val;
            r_lkp_hit      <= w_lkp_hit;
            r_lkp_dirty    <= w_lkp_hit && r_dirty[w_lkp_idx];
            r_lkp_data     <= w_lkp_hit ? r_data[w_lkp_idx] : '0;
        end
    end

    assign bus.ins_rdy      = !r_wb_val;
    assign bus.inv_hit      = w_inv_hit;
    assign bus.lkp_resp_val = r_lkp_resp_val;
    assign bus.lkp_hit      = r_lkp_hit;
    assign bus.lkp_data     = r_lkp_data;
    assign bus.lkp_dirty    = r_lkp_dirty;
    assign bus.wb_val       = r_wb_val;
    assign bus.wb_addr      = r_wb_addr;
    assign bus.wb_data      = r_wb_data;
    assign bus.count        = w_count;
endmodule

// File: tb/tb_l15_vc_assoc.sv
// tb/tb_l15_vc_assoc.sv - Scoreboard bench for the L1.5 victim cache
module tb_l15_vc_assoc;
    localparam int AW = 36;
    localparam int DW = 128;
    localparam int NE = 16;

    typedef struct packed {
        logic          hit;
        logic [DW-1:0] data;
        logic          dirty;
    } lkp_exp_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wb_exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    lkp_exp_t lkp_q[$];
    wb_exp_t  wb_q[$];
    lkp_exp_t m_lkp;
    wb_exp_t  m_wb;

    always #5 clk = ~clk;

    l15_vc_assoc_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_ENTRIES(NE)) bus ();

    l15_vc_assoc #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_ENTRIES(NE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Response monitor: pops expectations whenever the DUT presents a lookup response or writeback handshake
    always @(negedge clk) begin
        if (rst_n && bus.lkp_resp_val) begin
            if (lkp_q.size() == 0) begin
                check("lkp_unexpected_resp", 1, 0);
            end else begin
                m_lkp = lkp_q.pop_front();
                check("lkp_hit", DW'(bus.lkp_hit), DW'(m_lkp.hit));
                check("lkp_data", bus.lkp_data, m_lkp.data);
                check("lkp_dirty", DW'(bus.lkp_dirty), DW'(m_lkp.dirty));
            end
        end
        if (rst_n && bus.wb_val && bus.wb_rdy) begin
            if (wb_q.size() == 0) begin
                check("wb_unexpected", 1, 0);
            end else begin
                m_wb = wb_q.pop_front();
                check("wb_addr", DW'(bus.wb_addr), DW'(m_wb.addr));
                check("wb_data", bus.wb_data, m_wb.data);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        bus.ins_val = 1'b0;
        bus.lkp_val = 1'b0;
        bus.inv_val = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clr();
        bus.wb_rdy = 1'b0;
        lkp_q.delete();
        wb_q.delete();
        repeat (2) step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic ins(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic dirty);
        bus.ins_val   = 1'b1;
        bus.ins_addr  = a;
        bus.ins_data  = d;
        bus.ins_dirty = dirty;
        step();
        bus.ins_val = 1'b0;
    endtask

    task automatic expect_lkp(input logic hit, input logic [DW-1:0] d, input logic dirty);
        lkp_exp_t e;
        e.hit   = hit;
        e.data  = d;
        e.dirty = dirty;
        lkp_q.push_back(e);
    endtask

    task automatic lkp(input logic [AW-1:0] a, input logic hit, input logic [DW-1:0] d, input logic dirty);
        expect_lkp(hit, d, dirty);
        bus.lkp_val  = 1'b1;
        bus.lkp_addr = a;
        step();
        bus.lkp_val = 1'b0;
    endtask

    task automatic wb_drain(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wb_exp_t e;
        e.addr = a;
        e.data = d;
        wb_q.push_back(e);
        bus.wb_rdy = 1'b1;
        step();
        bus.wb_rdy = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clr();
        bus.ins_addr = '0; bus.ins_data = '0; bus.ins_dirty = 1'b0;
        bus.lkp_addr = '0; bus.inv_addr = '0; bus.wb_rdy = 1'b0;

        // Reset state, sampled while reset is held
        repeat (2) step();
        check("rst_count", DW'(bus.count), 0);
        check("rst_wb_val", DW'(bus.wb_val), 0);
        check("rst_lkp_resp_val", DW'(bus.lkp_resp_val), 0);
        check("rst_lkp_hit", DW'(bus.lkp_hit), 0);
        check("rst_lkp_data", bus.lkp_data, 0);
        check("rst_ins_rdy", DW'(bus.ins_rdy), 1);
        rst_n = 1'b1;
        step();

        // Insert then lookup hit removes the entry
        ins(36'h10, 128'hAA, 1'b0);
        check("t1_count_after_ins", DW'(bus.count), 1);
        lkp(36'h10, 1'b1, 128'hAA, 1'b0);
        check("t1_count_after_lkp", DW'(bus.count), 0);

        // Full of clean lines: 17th insert replaces entry 0 without writeback, rr moves to 1
        do_reset();
        for (int i = 0; i < NE; i++) ins(AW'(36'h100 + i), DW'(i), 1'b0);
        check("t2_count_full", DW'(bus.count), 16);
        ins(36'h200, 128'h55, 1'b0);
        check("t2_count_after_replace", DW'(bus.count), 16);
        check("t2_no_wb", DW'(bus.wb_val), 0);
        lkp(36'h100, 1'b0, 128'h0, 1'b0);
        lkp(36'h101, 1'b1, 128'h1, 1'b0);
        check("t2_count_after_hit", DW'(bus.count), 15);
        ins(36'h300, 128'h3, 1'b0);
        ins(36'h400, 128'h4, 1'b0);
        lkp(36'h300, 1'b0, 128'h0, 1'b0);
        lkp(36'h102, 1'b1, 128'h2, 1'b0);
        lkp(36'h200, 1'b1, 128'h55, 1'b0);

        // Dirty victim goes to writeback and blocks inserts until drained
        do_reset();
        for (int i = 0; i < NE; i++) ins(AW'(36'h500 + i), (i == 0) ? DW'(128'hD0) : DW'(i), i == 0);
        ins(36'h600, 128'h66, 1'b0);
        check("t3_wb_val", DW'(bus.wb_val), 1);
        check("t3_ins_rdy_low", DW'(bus.ins_rdy), 0);
        check("t3_wb_addr", DW'(bus.wb_addr), 36'h500);
        check("t3_wb_data", bus.wb_data, 128'hD0);
        ins(36'h700, 128'h77, 1'b0);
        step();
        check("t3_count_blocked", DW'(bus.count), 16);
        check("t3_wb_held", DW'(bus.wb_val), 1);
        check("t3_wb_addr_stable", DW'(bus.wb_addr), 36'h500);
        wb_drain(36'h500, 128'hD0);
        check("t3_wb_cleared", DW'(bus.wb_val), 0);
        check("t3_ins_rdy_back", DW'(bus.ins_rdy), 1);
        lkp(36'h700, 1'b0, 128'h0, 1'b0);
        lkp(36'h600, 1'b1, 128'h66, 1'b0);
        lkp(36'h501, 1'b1, 128'h1, 1'b0);

        // Invalidate dirty line writes it back; absent address misses
        do_reset();
        ins(36'h20, 128'hBEEF, 1'b1);
        bus.inv_val  = 1'b1;
        bus.inv_addr = 36'h20;
        #1;
        check("t4_inv_hit", DW'(bus.inv_hit), 1);
        step();
        clr();
        check("t4_wb_val", DW'(bus.wb_val), 1);
        check("t4_count", DW'(bus.count), 0);
        wb_drain(36'h20, 128'hBEEF);
        bus.inv_val  = 1'b1;
        bus.inv_addr = 36'h99;
        #1;
        check("t4_inv_miss", DW'(bus.inv_hit), 0);
        step();
        clr();
        check("t4_no_wb", DW'(bus.wb_val), 0);

        // Same-cycle interactions
        do_reset();
        bus.ins_val = 1'b1; bus.ins_addr = 36'h30; bus.ins_data = 128'h33; bus.ins_dirty = 1'b0;
        expect_lkp(1'b0, 128'h0, 1'b0);
        bus.lkp_val = 1'b1; bus.lkp_addr = 36'h30;
        step();
        clr();
        check("t5_count_ins_lkp", DW'(bus.count), 1);
        lkp(36'h30, 1'b1, 128'h33, 1'b0);
        ins(36'h40, 128'h44, 1'b0);
        bus.inv_val = 1'b1; bus.inv_addr = 36'h40;
        expect_lkp(1'b0, 128'h0, 1'b0);
        bus.lkp_val = 1'b1; bus.lkp_addr = 36'h40;
        #1;
        check("t5_inv_hit", DW'(bus.inv_hit), 1);
        step();
        clr();
        check("t5_count_after_inv", DW'(bus.count), 0);
        check("t5_no_wb", DW'(bus.wb_val), 0);
        ins(36'h50, 128'h5, 1'b0);
        bus.ins_val = 1'b1; bus.ins_addr = 36'h50; bus.ins_data = 128'h6; bus.ins_dirty = 1'b1;
        expect_lkp(1'b0, 128'h0, 1'b0);
        bus.lkp_val = 1'b1; bus.lkp_addr = 36'h50;
        step();
        clr();
        check("t5_count_overwrite", DW'(bus.count), 1);
        check("t5_overwrite_no_wb", DW'(bus.wb_val), 0);
        lkp(36'h50, 1'b1, 128'h6, 1'b1);

        // Reset while a writeback and a lookup response are pending
        do_reset();
        ins(36'h61, 128'h61, 1'b0);
        ins(36'h62, 128'h62, 1'b0);
        ins(36'h60, 128'h60, 1'b1);
        bus.inv_val = 1'b1; bus.inv_addr = 36'h60;
        bus.lkp_val = 1'b1; bus.lkp_addr = 36'h61;
        step();
        clr();
        check("t6_wb_pending", DW'(bus.wb_val), 1);
        check("t6_count_before", DW'(bus.count), 1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_wb_val", DW'(bus.wb_val), 0);
        check("t6_rst_count", DW'(bus.count), 0);
        check("t6_rst_lkp_resp", DW'(bus.lkp_resp_val), 0);
        do_reset();
        check("t6_ins_rdy", DW'(bus.ins_rdy), 1);

        step();
        check("lkp_queue_drained", DW'(lkp_q.size()), 0);
        check("wb_queue_drained", DW'(wb_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
